// File: rtl/dm_access_ctrl_if.sv
// CPU-side request/response channel of the data-memory access controller.
// The CPU drives requests through the master modport; the controller responds through the slave modport.
interface dm_access_ctrl_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dm_access_ctrl.sv
// Load/store front-end for the data memory: one request at a time, strobes held for fixed
// wait states, single-cycle response carrying read data or store readback plus mismatch flag.
module dm_access_ctrl #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int RD_WAIT = 2,
    parameter int WR_WAIT = 4,
    parameter int HOLD    = 1
) (
    input  logic              clk,
    input  logic              reset,
    dm_access_ctrl_if.slave   cpu,
    output logic              MemRead,
    output logic              MemWrite,
    output logic [ADDR_W-1:0] ABUS,
    output logic [DATA_W-1:0] DIN,
    input  logic [DATA_W-1:0] DATABUS
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    localparam logic [3:0] RD_LAST   = 4'(RD_WAIT - 1);
    localparam logic [3:0] WR_LAST   = 4'(WR_WAIT - 1);
    localparam logic [3:0] HOLD_LAST = 4'(HOLD - 1);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic [ADDR_W-1:0] abus_q, abus_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic [DATA_W-1:0] cap_q, cap_d;
    logic              req_ready_q, req_ready_d;
    logic              resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
    logic              resp_err_q, resp_err_d;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can infer a latch.
        state_d      = state_q;
        cnt_d        = cnt_q + 4'd1;
        mem_read_d   = 1'b0;
        mem_write_d  = 1'b0;
        abus_d       = abus_q;
        din_d        = din_q;
        cap_d        = cap_q;
        req_ready_d  = 1'b0;
        resp_valid_d = 1'b0;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;

        case (state_q)
            S_IDLE: begin
                cnt_d       = 4'd0;
                req_ready_d = 1'b1;
                if (cpu.req_valid && req_ready_q) begin
                    req_ready_d = 1'b0;
                    abus_d      = cpu.req_addr;
                    if (cpu.req_write) begin
                        state_d     = S_WR;
                        mem_write_d = 1'b1;
                        din_d       = cpu.req_wdata;
                    end else begin
                        state_d    = S_RD;
                        mem_read_d = 1'b1;
                    end
                end
            end

            S_RD: begin
                if (cnt_q == RD_LAST) begin
                    state_d      = S_IDLE;
                    cnt_d        = 4'd0;
                    req_ready_d  = 1'b1;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = DATABUS;
                    resp_err_d   = 1'b0;
                end else begin
                    mem_read_d = 1'b1;
                end
            end

            S_WR: begin
                if (cnt_q == WR_LAST) begin
                    cnt_d = 4'd0;
                    cap_d = DATABUS;
                    if (HOLD == 0) begin
                        state_d      = S_IDLE;
                        req_ready_d  = 1'b1;
                        resp_valid_d = 1'b1;
                        resp_rdata_d = DATABUS;
                        resp_err_d   = (DATABUS != din_q);
                    end else begin
                        state_d = S_HOLD;
                    end
                end else begin
                    mem_write_d = 1'b1;
                end
            end

            S_HOLD: begin
                // Readback was latched at the end of WR; it is only published on IDLE entry.
                if (cnt_q == HOLD_LAST) begin
                    state_d      = S_IDLE;
                    cnt_d        = 4'd0;
                    req_ready_d  = 1'b1;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = cap_q;
                    resp_err_d   = (cap_q != din_q);
                end
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state updates use non-blocking assignments so all flops sample the same pre-edge values.
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= 4'd0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            abus_q       <= '0;
            din_q        <= '0;
            cap_q        <= '0;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            abus_q       <= abus_d;
            din_q        <= din_d;
            cap_q        <= cap_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign MemRead        = mem_read_q;
    assign MemWrite       = mem_write_q;
    assign ABUS           = abus_q;
    assign DIN            = din_q;
    assign cpu.req_ready  = req_ready_q;
    assign cpu.resp_valid = resp_valid_q;
    assign cpu.resp_rdata = resp_rdata_q;
    assign cpu.resp_err   = resp_err_q;

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Directed bench for dm_access_ctrl: two instances (WR_WAIT=4 and WR_WAIT=1) each driving a
// behavioural data memory with ~10 read delay and 40 write-commit delay; scoreboarded responses.
module tb_dm_access_ctrl;
    localparam int AW       = 8;
    localparam int DW       = 8;
    localparam int TCLK     = 20;
    localparam int RD_WAIT  = 2;
    localparam int HOLD     = 1;
    localparam int WR_WAIT0 = 4;
    localparam int WR_WAIT1 = 1;

    typedef struct {
        logic [7:0] rdata;
        logic       err;
        int         lat;
        int         acc_cyc;
        int         id;
    } exp_t;

    logic clk = 1'b0;
    always #(TCLK / 2) clk = ~clk;

    logic [1:0]      rst;
    logic [1:0]      req_valid;
    logic [1:0]      req_write;
    logic [1:0][7:0] req_addr;
    logic [1:0][7:0] req_wdata;
    wire  [1:0]      req_ready;
    wire  [1:0]      resp_valid;
    wire  [1:0]      resp_err;
    wire  [1:0][7:0] resp_rdata;
    wire  [1:0]      mem_read;
    wire  [1:0]      mem_write;
    wire  [1:0][7:0] abus;
    wire  [1:0][7:0] din;
    wire  [1:0][7:0] databus;

    logic [7:0] mem [2][256];

    int   n_cmp  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    int   next_id = 0;
    exp_t sb0[$];
    exp_t sb1[$];
    exp_t mon_e;
    exp_t drop_e;
    int   mw_len[2], mw_last[2], mr_len[2], mr_last[2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        dm_access_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

        assign bus.req_valid  = req_valid[g];
        assign bus.req_write  = req_write[g];
        assign bus.req_addr   = req_addr[g];
        assign bus.req_wdata  = req_wdata[g];
        assign req_ready[g]   = bus.req_ready;
        assign resp_valid[g]  = bus.resp_valid;
        assign resp_rdata[g]  = bus.resp_rdata;
        assign resp_err[g]    = bus.resp_err;

        dm_access_ctrl #(
            .ADDR_W (AW),
            .DATA_W (DW),
            .RD_WAIT(RD_WAIT),
            .WR_WAIT(g == 0 ? WR_WAIT0 : WR_WAIT1),
            .HOLD   (HOLD)
        ) u_dut (
            .clk     (clk),
            .reset   (rst[g]),
            .cpu     (bus),
            .MemRead (mem_read[g]),
            .MemWrite(mem_write[g]),
            .ABUS    (abus[g]),
            .DIN     (din[g]),
            .DATABUS (databus[g])
        );

        // Read path: five taps stepped on odd time units, roughly 10 units behind ABUS.
        logic [7:0] pipe [5];
        int         wr_gen = 0;
        assign databus[g] = pipe[4];

        initial begin
            for (int i = 0; i < 5; i++) pipe[i] = 8'h00;
            #1;
            forever begin
                for (int i = 4; i > 0; i--) pipe[i] = pipe[i-1];
                pipe[0] = mem[g][abus[g]];
                #2;
            end
        end

        always @(negedge mem_write[g]) wr_gen++;

        // A write commits only if MemWrite stays high for longer than 40 units.
        always @(posedge mem_write[g]) begin : commit
            int         gen;
            logic [7:0] a;
            logic [7:0] d;
            #1;
            gen = wr_gen;
            a   = abus[g];
            d   = din[g];
            #40;
            if (mem_write[g] === 1'b1 && gen == wr_gen) mem[g][a] = d;
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst[k] !== 1'b1)
                check($sformatf("strobe_excl%0d", k), {31'b0, mem_read[k] & mem_write[k]}, 32'd0);

            if (mem_write[k] === 1'b1) mw_len[k]++;
            else if (mw_len[k] != 0) begin mw_last[k] = mw_len[k]; mw_len[k] = 0; end
            if (mem_read[k] === 1'b1) mr_len[k]++;
            else if (mr_len[k] != 0) begin mr_last[k] = mr_len[k]; mr_len[k] = 0; end

            if (resp_valid[k] === 1'b1) begin
                if ((k == 0 && sb0.size() == 0) || (k == 1 && sb1.size() == 0)) begin
                    check($sformatf("unexpected_resp%0d", k), {31'b0, resp_valid[k]}, 32'd0);
                end else begin
                    mon_e = (k == 0) ? sb0.pop_front() : sb1.pop_front();
                    check($sformatf("resp%0d_rdata", mon_e.id), {24'b0, resp_rdata[k]}, {24'b0, mon_e.rdata});
                    check($sformatf("resp%0d_err", mon_e.id), {31'b0, resp_err[k]}, {31'b0, mon_e.err});
                    check($sformatf("resp%0d_latency", mon_e.id), cyc - mon_e.acc_cyc, mon_e.lat);
                end
            end
        end
    end

    // Called at a negedge; returns at the negedge following the accepting edge.
    task automatic do_req(input int k, input logic wr, input logic [7:0] a, input logic [7:0] wd,
                          input logic [7:0] exp_rd, input logic exp_err, output int acc);
        exp_t e;
        int   n = 0;
        req_valid[k] = 1'b1;
        req_write[k] = wr;
        req_addr[k]  = a;
        req_wdata[k] = wd;
        while (req_ready[k] !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("accept_wait%0d", next_id), {31'b0, req_ready[k]}, 32'd1);
        acc       = cyc;
        e.rdata   = exp_rd;
        e.err     = exp_err;
        e.lat     = wr ? ((k == 0 ? WR_WAIT0 : WR_WAIT1) + HOLD + 1) : (RD_WAIT + 1);
        e.acc_cyc = acc;
        e.id      = next_id++;
        if (k == 0) sb0.push_back(e); else sb1.push_back(e);
        @(negedge clk);
        req_valid[k] = 1'b0;
        req_write[k] = ~wr;
        req_addr[k]  = ~a;
        req_wdata[k] = ~wd;
    endtask

    task automatic wait_idle(input int k);
        int n = 0;
        while (((k == 0) ? sb0.size() : sb1.size()) != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("drain%0d", k), (k == 0) ? sb0.size() : sb1.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #(TCLK * 20000);
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int a0, a1, a2;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 256; i++) mem[k][i] = 8'h00;
            mw_len[k] = 0; mw_last[k] = 0; mr_len[k] = 0; mr_last[k] = 0;
        end
        rst       = 2'b11;
        req_valid = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;

        // Reset held three cycles: every output low, including req_ready.
        repeat (3) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                check($sformatf("rst_ready%0d", k),  {31'b0, req_ready[k]},  32'd0);
                check($sformatf("rst_memrd%0d", k),  {31'b0, mem_read[k]},   32'd0);
                check($sformatf("rst_memwr%0d", k),  {31'b0, mem_write[k]},  32'd0);
                check($sformatf("rst_abus%0d", k),   {24'b0, abus[k]},       32'd0);
                check($sformatf("rst_din%0d", k),    {24'b0, din[k]},        32'd0);
                check($sformatf("rst_rvalid%0d", k), {31'b0, resp_valid[k]}, 32'd0);
                check($sformatf("rst_rdata%0d", k),  {24'b0, resp_rdata[k]}, 32'd0);
                check($sformatf("rst_rerr%0d", k),   {31'b0, resp_err[k]},   32'd0);
            end
        end
        rst = 2'b00;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("post_rst_ready%0d", k), {31'b0, req_ready[k]}, 32'd1);
            check($sformatf("post_rst_memwr%0d", k), {31'b0, mem_write[k]}, 32'd0);
            check($sformatf("post_rst_memrd%0d", k), {31'b0, mem_read[k]},  32'd0);
        end

        // Store 0xA5 @0x10, readback must match.
        do_req(0, 1'b1, 8'h10, 8'hA5, 8'hA5, 1'b0, a0);
        wait_idle(0);
        check("store_memwrite_len", mw_last[0], WR_WAIT0);
        check("store_abus_held", {24'b0, abus[0]}, 32'h10);
        check("store_din_held", {24'b0, din[0]}, 32'hA5);
        check("idle_memwrite_low", {31'b0, mem_write[0]}, 32'd0);

        // Load back 0xA5 from 0x10.
        do_req(0, 1'b0, 8'h10, 8'h00, 8'hA5, 1'b0, a0);
        wait_idle(0);
        check("load_memread_len", mr_last[0], RD_WAIT);

        // Load then store accepted on the load's response cycle; then read the top address back.
        do_req(0, 1'b0, 8'h10, 8'h00, 8'hA5, 1'b0, a0);
        do_req(0, 1'b1, 8'hFF, 8'h3C, 8'h3C, 1'b0, a1);
        check("b2b_no_gap", a1, a0 + RD_WAIT + 1);
        wait_idle(0);
        do_req(0, 1'b0, 8'hFF, 8'h00, 8'h3C, 1'b0, a2);
        wait_idle(0);

        // Short write pulse cannot commit: readback shows old contents and flags mismatch.
        do_req(1, 1'b1, 8'h20, 8'h77, 8'h00, 1'b1, a0);
        wait_idle(1);
        check("short_wr_memwrite_len", mw_last[1], WR_WAIT1);

        // Reset during the second WR cycle aborts the store without a response.
        do_req(0, 1'b1, 8'h40, 8'h99, 8'h00, 1'b0, a0);
        @(negedge clk);
        rst[0] = 1'b1;
        @(negedge clk);
        check("abort_memwrite", {31'b0, mem_write[0]}, 32'd0);
        check("abort_memread", {31'b0, mem_read[0]}, 32'd0);
        check("abort_rvalid", {31'b0, resp_valid[0]}, 32'd0);
        drop_e = sb0.pop_back();
        rst[0] = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("post_abort_memwrite", {31'b0, mem_write[0]}, 32'd0);
        end
        do_req(0, 1'b0, 8'h10, 8'h00, 8'hA5, 1'b0, a0);
        wait_idle(0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
